// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: next-PC select encoding, fetch FSM states, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

    // Next-PC select, matches the encoding the decoder drives on pc_src.
    localparam logic [1:0] PC_MUX_PLUS4  = 2'd0;
    localparam logic [1:0] PC_MUX_TARGET = 2'd1;
    localparam logic [1:0] PC_MUX_ALU    = 2'd2;
    localparam logic [1:0] PC_MUX_BREAK  = 2'd3;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection from the decoder's pc_src plus misalignment / ebreak detection.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: pc (current fetch PC), pc_src (select), pc_target (branch/jal target),
//        pc_alu (jalr sum) in; next_pc, misaligned, is_break out.
module pc_next
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] pc_alu,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned,
    output logic            is_break
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] w_raw;

    always_comb begin
        w_raw    = pc + PC_STEP;
        is_break = 1'b0;
        case (pc_src)
            PC_MUX_PLUS4:  w_raw = pc + PC_STEP;
            PC_MUX_TARGET: w_raw = pc_target;
            // jalr clears bit 0 of the sum before use
            PC_MUX_ALU:    w_raw = {pc_alu[XLEN-1:1], 1'b0};
            default: begin
                w_raw    = pc;
                is_break = 1'b1;
            end
        endcase
    end

    // Without the check, the low bits are silently dropped so fetch stays word aligned.
    assign next_pc    = ALIGN_CHECK ? w_raw : {w_raw[XLEN-1:2], 2'b00};
    assign misaligned = ALIGN_CHECK && !is_break && (w_raw[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: one outstanding req/gnt/rvalid read, hands word+PC to decode.
// Latency: retire -> next if_valid is 3 cycles minimum (req, rvalid, registered output).
// Backpressure: if_* held stable until id_ready; imem_req held until imem_gnt.
//
// Ports: clk/rst_n; imem_req/addr/gnt/rvalid/rdata/err memory handshake;
//        if_valid/instr/pc/pc4 toward decode with id_ready retire; pc_src/pc_target/pc_alu
//        next-PC inputs; resume/resume_pc leave HALT; halted and sticky fetch_err status.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_err,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    input  logic            id_ready,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] pc_alu,
    input  logic            resume,
    input  logic [XLEN-1:0] resume_pc,
    output logic            halted,
    output logic            fetch_err
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_req;
    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_pc4;
    logic            r_halted;
    logic            r_err;

    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;
    logic            w_is_break;
    logic [XLEN-1:0] w_pc4;

    assign w_pc4 = r_pc + PC_STEP;

    pc_next #(
        .XLEN        (XLEN),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_pc_next (
        .pc         (r_pc),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .pc_alu     (pc_alu),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned),
        .is_break   (w_is_break)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= REQ;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_instr  <= 32'h0;
            r_if_pc  <= RESET_PC;
            r_if_pc4 <= RESET_PC + PC_STEP;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                REQ: begin
                    // Out of reset the request is raised one cycle late; a gnt only
                    // counts once the request is actually visible on the bus.
                    if (r_req && imem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (imem_err) begin
                            r_err    <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_instr  <= imem_rdata;
                            r_if_pc  <= r_pc;
                            r_if_pc4 <= w_pc4;
                            r_valid  <= 1'b1;
                            r_state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        r_valid <= 1'b0;
                        if (w_is_break) begin
                            // pc keeps the ebreak address
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else if (w_misaligned) begin
                            r_err    <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end
                    end
                end
                HALT: begin
                    // Only sampled once already halted, so a pulse coincident with
                    // the entry into HALT is dropped.
                    if (resume) begin
                        r_pc     <= resume_pc;
                        r_err    <= 1'b0;
                        r_halted <= 1'b0;
                        r_req    <= 1'b1;
                        r_state  <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_valid;
    assign if_instr  = r_instr;
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc4;
    assign halted    = r_halted;
    assign fetch_err = r_err;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Multi-cycle instruction fetch stage that produces the instruction word, PC and PC+4 consumed by the instruction decoder.
- Closes the control loop from the other end: it takes the decoder's pc_src selection plus the branch-target and ALU results, computes the next PC, and issues the next instruction-memory read.
- Keeps one request outstanding over a req/gnt/rvalid memory handshake and handles ebreak halt, resume and fetch faults.

Parameters:
XLEN, 32, data and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
ALIGN_CHECK, 1, 1 = a next PC with bit[1:0] != 0 raises fetch_err; 0 = bit[1:0] is forced to 0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
imem_req  out  1  read request, held until granted
imem_addr  out  XLEN  word address, stable while imem_req=1
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; earliest the cycle after gnt
imem_rdata  in  32  instruction word
imem_err  in  1  bus error, qualified by imem_rvalid
if_valid  out  1  if_instr, if_pc and if_pc4 valid toward decode
if_instr  out  32  fetched instruction
if_pc  out  XLEN  address of if_instr
if_pc4  out  XLEN  if_pc + 4
id_ready  in  1  decode/execute retires the instruction this cycle
pc_src  in  2  decoder next-PC select, sampled on retire
pc_target  in  XLEN  if_pc + imm (branch/jal target)
pc_alu  in  XLEN  rs1 + imm (jalr)
resume  in  1  leave HALT, pulse
resume_pc  in  XLEN  fetch address used on resume
halted  out  1  core is stopped in HALT
fetch_err  out  1  sticky fault flag, cleared by resume

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=REQ.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc4=RESET_PC+4, halted=0, fetch_err=0.
  - Reset during any state aborts the access; a late rvalid after reset release is ignored (only rvalid in WAIT is accepted).
- FSM states: REQ, WAIT, HOLD, HALT.
  - REQ: imem_req=1, imem_addr=pc. On gnt go to WAIT; the request drops the cycle after gnt.
  - WAIT: on rvalid with imem_err=0, register if_instr=rdata, if_pc=pc, if_pc4=pc+4; if_valid=1 next cycle; go to HOLD. On rvalid with imem_err=1 set fetch_err and go to HALT; if_valid stays 0.
  - HOLD: if_valid=1; outputs stay stable until id_ready=1. On retire, if_valid drops next cycle and next_pc is computed from pc_src:
    - PLUS4 (0): pc+4
    - TARGET (1): pc_target
    - ALU (2): {pc_alu[XLEN-1:1], 1'b0}
    - BREAK (3): halt; pc holds the ebreak address
    - Non-break selections go to REQ with pc=next_pc.
    - If ALIGN_CHECK=1 and next_pc[1:0]!=0, set fetch_err, go to HALT, and leave pc unchanged.
  - HALT: halted=1; no requests issued. On resume: pc=resume_pc, fetch_err=0, halted=0, go to REQ. resume outside HALT is ignored.
- Timing:
  - Minimum latency from retire to the next if_valid is 3 cycles (REQ with gnt same cycle, rvalid the next cycle, registered if_valid).
  - gnt and rvalid in the same cycle is illegal; rvalid outside WAIT is ignored.
- Arithmetic: all PC arithmetic is modulo 2^XLEN; pc=32'hFFFF_FFFC with PLUS4 wraps to 0.
- Simultaneous events: id_ready while if_valid=0 has no effect. resume in the same cycle as entering HALT is ignored; a new pulse is required.

Decomposition:
- Shared package rv_pkg:
  - PC_MUX_PLUS4=0, PC_MUX_TARGET=1, PC_MUX_ALU=2, PC_MUX_BREAK=3, consistent with the decoder encoding.
  - fetch_state_t enum {REQ, WAIT, HOLD, HALT}.
  - RESET_PC default.
- Sub-module: pc_next. Purely combinational: pc, pc_src, pc_target, pc_alu in; next_pc, misaligned, is_break out.

Test Plan:
- Reset release with RESET_PC=0, gnt immediate, rvalid next cycle with 32'h00500093 -> if_valid=1 with if_pc=0, if_pc4=4, if_instr=32'h00500093, 3 cycles after reset release.
- Sequential stream, id_ready=1, pc_src=0, gnt delayed 2 cycles -> imem_addr steps 0,4,8; imem_req held through the stall; if_instr stable while id_ready=0.
- Retire at if_pc=8 with pc_src=1, pc_target=32'h40 -> next imem_addr=32'h40; pc_src=2, pc_alu=32'h81 -> imem_addr=32'h80.
- pc_src=3 at if_pc=32'h10 -> halted=1, no imem_req for 20 cycles; resume with resume_pc=32'h14 -> halted=0, imem_addr=32'h14.
- rvalid with imem_err=1 at pc=32'h20 -> fetch_err=1, halted=1, if_valid=0; pc_src=1 with pc_target=32'h42 -> fetch_err=1; resume clears fetch_err.
- rst_n asserted in WAIT, then rvalid arrives after release -> rvalid ignored, if_valid=0, fetch restarts at RESET_PC; pc=32'hFFFF_FFFC with PLUS4 -> imem_addr=0.
